// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl_pkg
// Brief   : Shared state encodings and width default for the serial adder.
// Revision: 1.0
// ============================================================================
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

endpackage : serial_adder_ctrl_pkg
`default_nettype wire

// File: rtl/serial_adder_ctrl_fulladder.sv
`default_nettype none
// ============================================================================
// Module  : Fulladder
// Brief   : Single-bit full adder used by the bit-serial datapath.
// Revision: 1.0
// ============================================================================
module Fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : Fulladder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl
// Brief   : Bit-serial LSB-first adder with IDLE/RUN/DONE control and flags.
// Revision: 1.0
// ============================================================================
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             inCarry,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] next_work;

    Fulladder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 lands at the LSB.
    assign next_work = {fa_s, {(WIDTH-1){1'b0}}} | (work >> 1);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            work     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= inA;
                        b_sh  <= inB;
                        carry <= inCarry;
                        work  <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    work  <= next_work;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB at this edge
                        sum      <= next_work;
                        carryOut <= fa_c;
                        overflow <= carry ^ fa_c;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder_ctrl
// Brief   : Scoreboard bench for serial_adder_ctrl at WIDTH=16.
// Revision: 1.0
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] inA = '0;
    logic [WIDTH-1:0] inB = '0;
    logic             inCarry = 1'b0;
    logic             ready, busy, done, carryOut, overflow;
    logic [WIDTH-1:0] sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit mon_en = 1'b0;

    exp_t             q[$];
    int               m_st = M_IDLE;
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_co = 1'b0;
    logic             m_ov = 1'b0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .start    (start),
        .inA      (inA),
        .inB      (inB),
        .inCarry  (inCarry),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryOut (carryOut),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic c);
        logic [WIDTH:0] full;
        exp_t e;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        e.s  = full[WIDTH-1:0];
        e.co = full[WIDTH];
        e.ov = (a[WIDTH-1] == b[WIDTH-1]) && (e.s[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference timing model; expected results are pushed at the accept edge.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_st  <= M_IDLE;
            m_cnt <= 0;
            m_sum <= '0;
            m_co  <= 1'b0;
            m_ov  <= 1'b0;
            q.delete();
        end else begin
            case (m_st)
                M_IDLE: if (start) begin
                    q.push_back(model_add(inA, inB, inCarry));
                    acc_cyc <= cyc + 1;
                    m_cnt   <= 0;
                    m_st    <= M_RUN;
                end
                M_RUN: if (m_cnt == WIDTH - 1) begin
                    m_sum <= q[0].s;
                    m_co  <= q[0].co;
                    m_ov  <= q[0].ov;
                    m_st  <= M_DONE;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: m_st <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("ready", ready, m_st == M_IDLE);
            check("busy", busy, m_st == M_RUN);
            check("done", done, m_st == M_DONE);
            check("onehot", 32'(ready) + 32'(busy) + 32'(done), 1);
            check("sum_held", sum, m_sum);
            check("cout_held", carryOut, m_co);
            check("ovf_held", overflow, m_ov);
            if (done) begin
                exp_t e;
                check("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("sum", sum, e.s);
                    check("carryOut", carryOut, e.co);
                    check("overflow", overflow, e.ov);
                    check("latency", cyc - acc_cyc, WIDTH);
                end
            end
        end
    end

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_st == M_IDLE && q.size() == 0) && n < max_cycles);
        if (n >= max_cycles) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("ready_timeout", 1, 0);
        inA = a; inB = b; inCarry = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(WIDTH + 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {carryOut, overflow}, 0);
        #2 rstN = 1'b1;
        mon_en = 1'b1;

        do_op(16'h0003, 16'h0005, 1'b0);
        check("dir_3p5", sum, 16'h0008);
        do_op(16'hFFFF, 16'h0001, 1'b0);
        check("dir_wrap", {carryOut, overflow, sum}, {2'b10, 16'h0000});
        do_op(16'h7FFF, 16'h0001, 1'b0);
        check("dir_ovf", {carryOut, overflow, sum}, {2'b01, 16'h8000});
        do_op(16'h0000, 16'h0000, 1'b1);
        check("dir_cin", {carryOut, overflow, sum}, {2'b00, 16'h0001});
        do_op(16'h8000, 16'h8000, 1'b0);
        check("dir_negovf", {carryOut, overflow, sum}, {2'b11, 16'h0000});
        do_op(16'hFFFF, 16'hFFFF, 1'b1);
        check("dir_allones", {carryOut, overflow, sum}, {2'b10, 16'hFFFF});

        for (int i = 0; i < 6; i++)
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));

        // start held high with operands churning; only accept-edge values count
        @(negedge clk);
        inA = 16'h1357; inB = 16'h2468; inCarry = 1'b1; start = 1'b1;
        for (int i = 0; i < 2 * (WIDTH + 2) + 3; i++) begin
            @(posedge clk);
            #1;
            inA = WIDTH'($urandom); inB = WIDTH'($urandom); inCarry = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle(2 * (WIDTH + 4));

        // asynchronous reset while bit 7 is in flight
        @(negedge clk);
        inA = 16'h1234; inB = 16'h1111; inCarry = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 64 && !(m_st == M_RUN && m_cnt == 7); n++) @(negedge clk);
        check("reached_bit7", m_cnt, 7);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        check("arst_ready", ready, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_out", {carryOut, overflow, sum}, 0);
        repeat (3) @(negedge clk);
        check("arst_hold", {done, carryOut, overflow, sum}, 0);
        #2 rstN = 1'b1;
        do_op(16'h1234, 16'h1111, 1'b0);
        check("post_rst", sum, 16'h2345);

        repeat (2) @(negedge clk);
        check("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
